weighted_round_robin_arbiter: RTL and testbench
===============================================

WEIGHTED_ROUND_ROBIN_ARBITER -- requirements
Module: weighted_round_robin_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (N >= 1).
REQ-002 SHALL have parameter WEIGHT_W, default 3, meaning width of each per-requester weight.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port requests, input, N, meaning bit i high when requester i wants service.
REQ-006 SHALL have port weights, input, N*WEIGHT_W, meaning weight of requester i at bits [i*WEIGHT_W +: WEIGHT_W], as max consecutive transfers per turn.
REQ-007 SHALL have port ready, input, 1, meaning downstream accepts the granted requester this cycle.
REQ-008 SHALL have port grants, output, N, meaning one-hot grant, or all-zero when nothing is granted.
REQ-009 SHALL have port grant_valid, output, 1, meaning OR of grants.
REQ-010 SHALL have port grant_id, output, max(1,$clog2(N)), meaning index of the granted bit, 0 when grant_valid is low.

Function
REQ-011 SHALL compute grants, grant_valid and grant_id combinationally from current state and requests, with zero-cycle latency.
REQ-012 SHALL define transfer as grant_valid & ready in a cycle; only transfers advance state.
REQ-013 SHALL hold state ptr (next-preferred index, 0..N-1), mode IDLE/LOCKED, owner index, burst count, and latched weight.
REQ-014 In IDLE, SHALL grant the first set request found by searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ...).
REQ-015 SHALL treat weight 0 as weight 1.
REQ-016 On an IDLE transfer to requester k with effective weight 1, SHALL set ptr to (k+1) mod N and remain in IDLE.
REQ-017 On an IDLE transfer to requester k with effective weight w > 1, SHALL enter LOCKED, set owner = k, latch w, and set count = 1.
REQ-018 In LOCKED with requests[owner] high, SHALL grant owner only, regardless of other requests.
REQ-019 On a LOCKED transfer, SHALL increment count; when the incremented count equals the latched w, SHALL return to IDLE with ptr = (owner+1) mod N.
REQ-020 In LOCKED with no transfer (ready low), SHALL hold owner, count and ptr unchanged.
REQ-021 In LOCKED with requests[owner] low, SHALL abort the burst in that cycle: arbitrate as IDLE searching from (owner+1) mod N, with next state per REQ-016/017 for that grant (IDLE with ptr = (owner+1) mod N if there is no transfer).
REQ-022 SHALL ignore changes to weights during a burst; weight is sampled only at burst start.
REQ-023 In IDLE with no transfer, SHALL keep ptr unchanged; grants may change as requests change.
REQ-024 SHALL wrap ptr from N-1 to 0.
REQ-025 With N = 1, SHALL set grants = requests, keep ptr at 0, and still honour the weight and LOCKED count.
REQ-026 With all weights 1 and ready tied high, SHALL reproduce the classic round-robin sequence of the 2-request arbiter.

Reset
REQ-027 While rst is high, SHALL force grants = 0, grant_valid = 0 and grant_id = 0.
REQ-028 On a clock edge with rst high, SHALL set ptr = 0, mode = IDLE, owner = 0, count = 0; rst overrides any simultaneous transfer.
REQ-029 Reset mid-burst SHALL discard the burst; the first cycle after reset SHALL arbitrate from index 0.

Verification
REQ-030 N=4, all weights 1, ready=1, requests=1111 for 5 cycles -> grants 0001, 0010, 0100, 1000, 0001.
REQ-031 N=2, weights 1, ready=1, requests 01 00 10 11 11 00 11 00 11 11 -> grants 01 00 10 01 10 00 01 00 10 01.
REQ-032 N=4, weight0=3 and others 1, ready=1, requests=0011 -> grants 0001, 0001, 0001, 0010, 0001, 0001, 0001.
REQ-033 Weight0=3, requests=0011: ready=1, then ready=0 for 2 cycles, then ready=1 -> grant held at 0001 throughout; burst completes after 3 transfers, then 0010.
REQ-034 Weight0=3, requests 0101 mid-burst (count=1): drop requests[0] -> same cycle grants=0100; after transfer, ptr=3.
REQ-035 Reset asserted mid-burst with requests=1010 -> grants=0000 during rst; first cycle after reset grants=0010.

Source files
------------

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter.
// Each requester may hold the grant for up to its weight in consecutive
// transfers. A weight of 0 counts as 1. Grants are combinational from the
// current state and requests. State only advances on a transfer
// (grant_valid & ready), except that a dropped owner request ends a burst.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | plain round-robin search starting at ptr
// LOCKED | owner keeps the grant while it requests, until count == weight
module weighted_round_robin_arbiter #(
    parameter int N = 4,
    parameter int WEIGHT_W = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          requests,
    input  logic [N*WEIGHT_W-1:0] weights,
    input  logic                  ready,
    output logic [N-1:0]          grants,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_id
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       owner_q;
    logic [WEIGHT_W-1:0] count_q;
    logic [WEIGHT_W-1:0] wlatch_q;

    logic                owner_req;
    logic                hold_owner;
    logic [IW-1:0]       start;
    logic [IW-1:0]       sel;
    logic                sel_found;
    logic [WEIGHT_W-1:0] sel_w;
    logic [WEIGHT_W-1:0] eff_w;
    logic                transfer;

    // Modulo-N increment; the index never exceeds N-1.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // Pick the granted requester: the owner while its burst continues,
    // otherwise the first set request found circularly from the start index.
    always_comb begin
        int idx;
        idx        = 0;
        owner_req  = 1'b0;
        sel        = '0;
        sel_found  = 1'b0;
        sel_w      = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q == IW'(k)) owner_req = requests[k];
        end
        hold_owner = (state_q == LOCKED) && owner_req && !rst;
        // An aborted burst searches from the slot after the owner.
        start      = (state_q == LOCKED) ? next_idx(owner_q) : ptr_q;
        if (hold_owner) begin
            sel       = owner_q;
            sel_found = 1'b1;
        end else if (!rst) begin
            for (int off = 0; off < N; off++) begin
                idx = int'(start) + off;
                if (idx >= N) idx = idx - N;
                if (!sel_found && requests[idx]) begin
                    sel       = IW'(idx);
                    sel_found = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (sel == IW'(k)) sel_w = weights[k*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Drive one-hot grant, its index and the valid flag from the selection.
    always_comb begin
        grants = '0;
        for (int k = 0; k < N; k++) begin
            grants[k] = sel_found && (sel == IW'(k));
        end
        grant_valid = sel_found;
        grant_id    = sel_found ? sel : '0;
        eff_w       = (sel_w == '0) ? WEIGHT_W'(1) : sel_w;
        transfer    = sel_found && ready;
    end

    // Arbitration state: pointer, burst mode, owner, burst count, latched weight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            count_q  <= '0;
            wlatch_q <= '0;
        end else if (hold_owner) begin
            if (ready) begin
                if (count_q + 1'b1 == wlatch_q) begin
                    state_q <= IDLE;
                    ptr_q   <= next_idx(owner_q);
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end else begin
            // Owner dropped its request: the burst ends whether or not
            // the replacement grant transfers.
            if (state_q == LOCKED) begin
                state_q <= IDLE;
                ptr_q   <= next_idx(owner_q);
            end
            if (transfer) begin
                if (eff_w == WEIGHT_W'(1)) begin
                    state_q <= IDLE;
                    ptr_q   <= next_idx(sel);
                end else begin
                    state_q  <= LOCKED;
                    owner_q  <= sel;
                    wlatch_q <= eff_w;
                    count_q  <= WEIGHT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Testbench for weighted_round_robin_arbiter: directed scenarios with
// constant expectations plus randomized traffic against a behavioural model,
// exercising N = 4, N = 2 and N = 1 instances.
module tb_weighted_round_robin_arbiter;

    typedef struct packed {
        int ptr;
        bit locked;
        int owner;
        int count;
        int w;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]  req4;  logic [11:0] wts4; logic rdy4;
    logic [3:0]  g4;    logic v4;          logic [1:0] id4;
    logic [1:0]  req2;  logic [5:0]  wts2; logic rdy2;
    logic [1:0]  g2;    logic v2;          logic id2;
    logic        req1;  logic [2:0]  wts1; logic rdy1;
    logic        g1;    logic v1;          logic id1;

    int w4[4];
    int w2[4];
    int w1[4];
    int n_checks = 0;
    int n_fail = 0;
    mstate_t m4, m2, m1;

    weighted_round_robin_arbiter #(.N(4), .WEIGHT_W(3)) dut4 (
        .clk(clk), .rst(rst), .requests(req4), .weights(wts4), .ready(rdy4),
        .grants(g4), .grant_valid(v4), .grant_id(id4));
    weighted_round_robin_arbiter #(.N(2), .WEIGHT_W(3)) dut2 (
        .clk(clk), .rst(rst), .requests(req2), .weights(wts2), .ready(rdy2),
        .grants(g2), .grant_valid(v2), .grant_id(id2));
    weighted_round_robin_arbiter #(.N(1), .WEIGHT_W(3)) dut1 (
        .clk(clk), .rst(rst), .requests(req1), .weights(wts1), .ready(rdy1),
        .grants(g1), .grant_valid(v1), .grant_id(id1));

    // Requester that the rules grant this cycle, or -1.
    function automatic int m_pick(mstate_t s, int n, logic [3:0] req);
        int start;
        if (s.locked && req[s.owner]) return s.owner;
        start = s.locked ? (s.owner + 1) % n : s.ptr;
        for (int o = 0; o < n; o++) begin
            if (req[(start + o) % n]) return (start + o) % n;
        end
        return -1;
    endfunction

    // Arbiter state after a clock edge with these inputs.
    function automatic mstate_t m_next(mstate_t s, int n, logic [3:0] req, int w[4], bit rdy);
        mstate_t r;
        int g;
        int ew;
        r = s;
        g = m_pick(s, n, req);
        if (s.locked && req[s.owner]) begin
            if (rdy) begin
                r.count = s.count + 1;
                if (r.count == s.w) begin
                    r.locked = 1'b0;
                    r.ptr = (s.owner + 1) % n;
                end
            end
            return r;
        end
        if (s.locked) begin
            r.locked = 1'b0;
            r.ptr = (s.owner + 1) % n;
        end
        if (g >= 0 && rdy) begin
            ew = (w[g] == 0) ? 1 : w[g];
            if (ew == 1) begin
                r.ptr = (g + 1) % n;
            end else begin
                r.locked = 1'b1;
                r.owner = g;
                r.w = ew;
                r.count = 1;
            end
        end
        return r;
    endfunction

    task automatic set_w4(input int a, input int b, input int c, input int d);
        w4[0] = a; w4[1] = b; w4[2] = c; w4[3] = d;
        wts4 = {3'(d), 3'(c), 3'(b), 3'(a)};
    endtask

    task automatic set_w2(input int a, input int b);
        w2[0] = a; w2[1] = b; w2[2] = 0; w2[3] = 0;
        wts2 = {3'(b), 3'(a)};
    endtask

    task automatic set_w1(input int a);
        w1[0] = a; w1[1] = 0; w1[2] = 0; w1[3] = 0;
        wts1 = 3'(a);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req4 = '0; rdy4 = 1'b0;
        req2 = '0; rdy2 = 1'b0;
        req1 = 1'b0; rdy1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m4 = '0; m2 = '0; m1 = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        req4 = 4'b1111; rdy4 = 1'b1;
        req2 = 2'b11;   rdy2 = 1'b1;
        req1 = 1'b1;    rdy1 = 1'b1;
        #1;
        n_checks++; if (g4 !== 4'b0) begin n_fail++; $display("FAIL reset_g4: got %b expected 0000", g4); end
        n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL reset_v4: got %b expected 0", v4); end
        n_checks++; if (id4 !== 2'd0) begin n_fail++; $display("FAIL reset_id4: got %0d expected 0", id4); end
        n_checks++; if (g2 !== 2'b0) begin n_fail++; $display("FAIL reset_g2: got %b expected 00", g2); end
        n_checks++; if (g1 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL reset_n1: got g=%b v=%b expected 0 0", g1, v1); end
        @(posedge clk); #1;
        n_checks++; if (g4 !== 4'b0) begin n_fail++; $display("FAIL reset_hold_g4: got %b expected 0000", g4); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (g4 !== 4'b0001) begin n_fail++; $display("FAIL reset_release_g4: got %b expected 0001", g4); end
        rdy4 = 1'b0; rdy2 = 1'b0; rdy1 = 1'b0;
    endtask

    task automatic test_rr_basic;
        logic [3:0] exp4 [5];
        exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        set_w4(1, 1, 1, 1);
        do_reset;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req4 = 4'b1111; rdy4 = 1'b1;
            #1;
            n_checks++;
            if (g4 !== exp4[i]) begin n_fail++; $display("FAIL rr_basic[%0d]: got %b expected %b", i, g4, exp4[i]); end
        end
        rdy4 = 1'b0;
    endtask

    task automatic test_two_req;
        logic [1:0] rq [10];
        logic [1:0] ex [10];
        rq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
        ex = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
        set_w2(1, 1);
        do_reset;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req2 = rq[i]; rdy2 = 1'b1;
            #1;
            n_checks++;
            if (g2 !== ex[i] || v2 !== (|ex[i])) begin
                n_fail++; $display("FAIL two_req[%0d]: got %b/%b expected %b/%b", i, g2, v2, ex[i], |ex[i]);
            end
        end
        rdy2 = 1'b0;
    endtask

    task automatic test_weighted_burst;
        logic [3:0] ex [7];
        ex = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
        set_w4(3, 1, 1, 1);
        do_reset;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req4 = 4'b0011; rdy4 = 1'b1;
            #1;
            n_checks++;
            if (g4 !== ex[i]) begin n_fail++; $display("FAIL weighted_burst[%0d]: got %b expected %b", i, g4, ex[i]); end
        end
        rdy4 = 1'b0;
    endtask

    task automatic test_ready_stall;
        logic rd [6];
        logic [3:0] ex [6];
        rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ex = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        set_w4(3, 1, 1, 1);
        do_reset;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req4 = 4'b0011; rdy4 = rd[i];
            #1;
            n_checks++;
            if (g4 !== ex[i]) begin n_fail++; $display("FAIL ready_stall[%0d]: got %b expected %b", i, g4, ex[i]); end
        end
        rdy4 = 1'b0;
    endtask

    task automatic test_abort;
        logic [3:0] rq [3];
        logic [3:0] ex [3];
        rq = '{4'b0101, 4'b0100, 4'b1111};
        ex = '{4'b0001, 4'b0100, 4'b1000};
        set_w4(3, 1, 1, 1);
        do_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req4 = rq[i]; rdy4 = 1'b1;
            #1;
            n_checks++;
            if (g4 !== ex[i]) begin n_fail++; $display("FAIL abort[%0d]: got %b expected %b", i, g4, ex[i]); end
        end
        rdy4 = 1'b0;
    endtask

    task automatic test_weight_freeze;
        logic [3:0] ex [3];
        ex = '{4'b0001, 4'b0001, 4'b0010};
        set_w4(2, 1, 1, 1);
        do_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) set_w4(7, 1, 1, 1);
            req4 = 4'b0011; rdy4 = 1'b1;
            #1;
            n_checks++;
            if (g4 !== ex[i]) begin n_fail++; $display("FAIL weight_freeze[%0d]: got %b expected %b", i, g4, ex[i]); end
        end
        rdy4 = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        set_w4(1, 1, 1, 3);
        do_reset;
        @(negedge clk);
        req4 = 4'b1000; rdy4 = 1'b1;
        #1;
        n_checks++; if (g4 !== 4'b1000) begin n_fail++; $display("FAIL rmb_start: got %b expected 1000", g4); end
        @(negedge clk);
        rst = 1'b1; req4 = 4'b1010;
        #1;
        n_checks++; if (g4 !== 4'b0000 || v4 !== 1'b0) begin n_fail++; $display("FAIL rmb_in_reset: got %b/%b expected 0000/0", g4, v4); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (g4 !== 4'b0010 || id4 !== 2'd1) begin n_fail++; $display("FAIL rmb_after: got %b id %0d expected 0010 id 1", g4, id4); end
        rdy4 = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] e4;
        logic [1:0] e2;
        int p4, p2, p1;
        do_reset;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i % 23 == 0) begin
                set_w4($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                set_w2($urandom_range(0, 7), $urandom_range(0, 7));
                set_w1($urandom_range(0, 7));
            end
            rst  = ($urandom_range(0, 63) == 0);
            req4 = 4'($urandom);           rdy4 = ($urandom_range(0, 3) != 0);
            req2 = 2'($urandom);           rdy2 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 4) != 0); rdy1 = ($urandom_range(0, 2) != 0);
            #1;
            p4 = rst ? -1 : m_pick(m4, 4, req4);
            p2 = rst ? -1 : m_pick(m2, 2, {2'b00, req2});
            p1 = rst ? -1 : m_pick(m1, 1, {3'b000, req1});
            e4 = (p4 < 0) ? 4'b0 : 4'(1 << p4);
            e2 = (p2 < 0) ? 2'b0 : 2'(1 << p2);
            n_checks++;
            if (g4 !== e4 || v4 !== (p4 >= 0) || id4 !== 2'((p4 < 0) ? 0 : p4)) begin
                n_fail++; $display("FAIL random_n4[%0d]: got %b/%b/%0d expected %b/%b/%0d", i, g4, v4, id4, e4, p4 >= 0, (p4 < 0) ? 0 : p4);
            end
            n_checks++;
            if (g2 !== e2 || v2 !== (p2 >= 0) || id2 !== 1'((p2 < 0) ? 0 : p2)) begin
                n_fail++; $display("FAIL random_n2[%0d]: got %b/%b/%0d expected %b/%b/%0d", i, g2, v2, id2, e2, p2 >= 0, (p2 < 0) ? 0 : p2);
            end
            n_checks++;
            if (g1 !== (p1 >= 0) || v1 !== (p1 >= 0) || id1 !== 1'b0) begin
                n_fail++; $display("FAIL random_n1[%0d]: got %b/%b/%0d expected %b/%b/0", i, g1, v1, id1, p1 >= 0, p1 >= 0);
            end
            @(posedge clk);
            if (rst) begin
                m4 = '0; m2 = '0; m1 = '0;
            end else begin
                m4 = m_next(m4, 4, req4, w4, rdy4);
                m2 = m_next(m2, 2, {2'b00, req2}, w2, rdy2);
                m1 = m_next(m1, 1, {3'b000, req1}, w1, rdy1);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req4 = '0; rdy4 = 1'b0;
        req2 = '0; rdy2 = 1'b0;
        req1 = 1'b0; rdy1 = 1'b0;
        set_w4(1, 1, 1, 1);
        set_w2(1, 1);
        set_w1(1);
        test_reset;
        test_rr_basic;
        test_two_req;
        test_weighted_burst;
        test_ready_stall;
        test_abort;
        test_weight_freeze;
        test_reset_mid_burst;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
